// File: rtl/aes_job_arbiter_pkg.sv
// aes_job_arbiter_pkg: shared FSM states, mode encodings and width helpers for the AES job arbiter.
package aes_job_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, BUSY, RESP} state_e;
  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;
  function automatic int unsigned tw(input int unsigned t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction
endpackage

// File: rtl/aes_job_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; ptr names the requester preferred when both ask.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic       gnt_o,
  output logic       any_o
);
  assign any_o = |req_i;
  assign gnt_o = req_i[ptr_i] ? ptr_i : ~ptr_i;
endmodule

// File: rtl/aes_job_arbiter.sv
// aes_job_arbiter: shares one AES SPI Master between two requesters, with watchdog and
// valid/ready result return; the Master and enc/dec units sit outside on the m_* ports.
module aes_job_arbiter
  import aes_job_arbiter_pkg::*;
#(
  parameter  int NK      = 6,
  parameter  int NB      = 4,
  parameter  int NR      = 12,
  parameter  int TIMEOUT = 4096,
  localparam int KW      = 32 * NK,
  localparam int DW      = 32 * NB,
  localparam int TW      = tw(TIMEOUT)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [1:0]    req_valid_i,
  output logic [1:0]    req_ready_o,
  input  logic          req0_mode_i,
  input  logic          req1_mode_i,
  input  logic [DW-1:0] req0_msg_i,
  input  logic [DW-1:0] req1_msg_i,
  input  logic [KW-1:0] req0_key_i,
  input  logic [KW-1:0] req1_key_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic          rsp_id_o,
  output logic          rsp_err_o,
  output logic [DW-1:0] rsp_data_o,
  output logic          m_valid_o,
  output logic          m_mode_o,
  output logic [DW-1:0] m_msg_o,
  output logic [KW-1:0] m_key_o,
  input  logic          m_done_i,
  input  logic [DW-1:0] m_result_i,
  output logic          m_abort_o,
  output logic          busy_o,
  output logic [15:0]   job_cnt_o,
  output logic [7:0]    err_cnt_o
);
  if (NR != NK + 6) begin : g_nr_bad
    $error("NR must equal NK+6");
  end
  state_e state_q, state_d;
  logic ptr_q, ptr_d, id_q, id_d, err_q, err_d, mode_q, mode_d;
  logic [DW-1:0] data_q, data_d, msg_q, msg_d;
  logic [KW-1:0] key_q, key_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0] job_q, job_d;
  logic [7:0] errc_q, errc_d;
  logic gnt, any, expired;
  rr_arb2 u_arb (
    .req_i(req_valid_i),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .any_o(any)
  );
  assign expired = timer_q == TW'(TIMEOUT - 1);
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    err_d     = err_q;
    mode_d    = mode_q;
    data_d    = data_q;
    msg_d     = msg_q;
    key_d     = key_q;
    timer_d   = timer_q;
    job_d     = job_q;
    errc_d    = errc_q;
    m_abort_o = 1'b0;
    case (state_q)
      IDLE: if (any) begin
        state_d = LOAD;
        id_d    = gnt;
        mode_d  = (gnt ? req1_mode_i : req0_mode_i) ? MODE_DEC : MODE_ENC;
        msg_d   = gnt ? req1_msg_i : req0_msg_i;
        key_d   = gnt ? req1_key_i : req0_key_i;
      end
      LOAD: begin
        timer_d = '0;
        state_d = BUSY;
      end
      BUSY: begin
        timer_d = timer_q + TW'(1);
        // a completion arriving on the expiry cycle still counts as success
        if (m_done_i) begin
          data_d  = m_result_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (expired) begin
          m_abort_o = 1'b1;
          err_d     = 1'b1;
          data_d    = '0;
          errc_d    = errc_q + {7'd0, ~&errc_q};
          state_d   = RESP;
        end
      end
      RESP: if (rsp_ready_i) begin
        job_d   = job_q + 16'd1;
        ptr_d   = ~id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      mode_q  <= MODE_ENC;
      data_q  <= '0;
      msg_q   <= '0;
      key_q   <= '0;
      timer_q <= '0;
      job_q   <= '0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      err_q   <= err_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      msg_q   <= msg_d;
      key_q   <= key_d;
      timer_q <= timer_d;
      job_q   <= job_d;
      errc_q  <= errc_d;
    end
  end
  // ready is gated by reset so a held request never sees a grant while in reset
  assign req_ready_o = (rst_ni && state_q == IDLE && any) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid_o = state_q == RESP;
  assign rsp_id_o    = id_q;
  assign rsp_err_o   = err_q;
  assign rsp_data_o  = data_q;
  assign m_valid_o   = state_q != IDLE;
  assign m_mode_o    = mode_q;
  assign m_msg_o     = msg_q;
  assign m_key_o     = key_q;
  assign busy_o      = state_q != IDLE;
  assign job_cnt_o   = job_q;
  assign err_cnt_o   = errc_q;
endmodule

// File: tb/tb_aes_job_arbiter.sv
// tb_aes_job_arbiter: randomized scoreboard bench with a behavioural Master model and
// a transaction-level model of arbitration, watchdog and counters.
module tb_aes_job_arbiter;
  localparam int DW = 128;
  localparam int KW = 192;
  localparam int TO = 16;
  localparam logic [KW-1:0] K1 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [DW-1:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [DW-1:0] C1 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

  typedef struct packed {
    logic          id;
    logic          err;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 0, rst_n = 0;
  logic [1:0] req_valid = 0;
  logic [1:0] req_ready;
  logic mode_v [2];
  logic [DW-1:0] msg_v [2];
  logic [KW-1:0] key_v [2];
  logic rsp_valid, rsp_ready = 0, rsp_id, rsp_err;
  logic [DW-1:0] rsp_data;
  logic m_valid, m_mode, m_abort, busy;
  logic [DW-1:0] m_msg, m_result = 0;
  logic [KW-1:0] m_key;
  logic m_done = 0;
  logic [15:0] job_cnt;
  logic [7:0] err_cnt;

  int checks = 0, passes = 0;
  exp_t sb[$];
  exp_t e;
  bit outst = 0, pref = 0, hold_prev = 0, stall = 0, hold = 0, rand_rdy = 0;
  bit acc [2];
  logic [DW+1:0] held;
  logic [1:0] exp_rdy;
  logic g;
  int vcnt = 0, aborts = 0;
  logic [15:0] jobs = 0;
  logic [7:0] errs = 0;

  aes_job_arbiter #(.NK(6), .NB(4), .NR(12), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req0_mode_i(mode_v[0]), .req1_mode_i(mode_v[1]),
    .req0_msg_i(msg_v[0]), .req1_msg_i(msg_v[1]),
    .req0_key_i(key_v[0]), .req1_key_i(key_v[1]),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_err_o(rsp_err), .rsp_data_o(rsp_data),
    .m_valid_o(m_valid), .m_mode_o(m_mode), .m_msg_o(m_msg), .m_key_o(m_key),
    .m_done_i(m_done), .m_result_i(m_result), .m_abort_o(m_abort),
    .busy_o(busy), .job_cnt_o(job_cnt), .err_cnt_o(err_cnt)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm, input logic [255:0] a, input logic [255:0] x);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, x);
  endtask

  // Stand-in cipher: the real AES pair for the known vector, a keyed mix otherwise.
  function automatic logic [DW-1:0] cipher(input logic md, input logic [DW-1:0] m, input logic [KW-1:0] k);
    if (k == K1 && !md && m == P1) return C1;
    if (k == K1 && md && m == C1) return P1;
    return {m[DW-2:0], m[DW-1]} ^ k[DW-1:0] ^ {DW{md}};
  endfunction

  function automatic logic [DW-1:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic issue(input int i, input logic md, input logic [DW-1:0] ms, input logic [KW-1:0] ky);
    int n = 0;
    msg_v[i] = ms; key_v[i] = ky; mode_v[i] = md; acc[i] = 0; req_valid[i] = 1'b1;
    do begin @(posedge clk); n++; end while (!acc[i] && n < 2000);
    #1 req_valid[i] = 1'b0;
    chk(acc[i], "accept", 256'(acc[i]), 1);
  endtask

  task automatic issue_rand(input int i);
    issue(i, 1'($urandom_range(0, 1)), r128(), {r128(), 64'($urandom), 32'($urandom)});
  endtask

  task automatic drain();
    int n = 0;
    while ((outst || sb.size() != 0) && n < 3000) begin @(posedge clk); n++; end
    #1 chk(n < 3000, "drain", 256'(n), 3000);
  endtask

  task automatic check_zero(input string nm);
    chk({req_ready, rsp_valid, rsp_id, rsp_err, m_valid, m_mode, m_abort, busy, job_cnt, err_cnt} == 0,
        {nm, "_ctl"}, {req_ready, rsp_valid, rsp_id, rsp_err, m_valid, m_mode, m_abort, busy, job_cnt, err_cnt}, 0);
    chk(rsp_data == 0, {nm, "_rsp_data"}, rsp_data, 0);
    chk(m_msg == 0, {nm, "_m_msg"}, m_msg, 0);
    chk(m_key == 0, {nm, "_m_key"}, m_key, 0);
  endtask

  // Monitor: transaction-level model of arbitration, handshakes and watchdog timing.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete(); outst = 0; pref = 0; jobs = 0; errs = 0; vcnt = 0; hold_prev = 0;
    end else begin
      vcnt = m_valid ? vcnt + 1 : 0;
      if (m_abort) aborts++;
      chk(busy == outst, "busy", 256'(busy), 256'(outst));
      chk(m_valid == outst, "m_valid", 256'(m_valid), 256'(outst));
      chk(m_abort == (stall && outst && vcnt == TO + 1), "m_abort", 256'(m_abort), 256'(stall && outst && vcnt == TO + 1));
      exp_rdy = outst ? 2'b00 : (req_valid == 2'b11 ? (pref ? 2'b10 : 2'b01) : req_valid);
      chk(req_ready == exp_rdy, "req_ready", 256'(req_ready), 256'(exp_rdy));
      if (hold_prev) chk(rsp_valid && {rsp_id, rsp_err, rsp_data} == held, "rsp_stable", {rsp_valid, rsp_id, rsp_err, rsp_data}, {1'b1, held});
      hold_prev = 0;
      if (rsp_valid) begin
        if (rsp_ready) begin
          chk(sb.size() != 0, "rsp_expected", 256'(sb.size()), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk(rsp_id == e.id, "rsp_id", 256'(rsp_id), 256'(e.id));
            chk(rsp_err == e.err, "rsp_err", 256'(rsp_err), 256'(e.err));
            chk(rsp_data == e.data, "rsp_data", rsp_data, e.data);
            pref = ~e.id;
          end
          outst = 0; jobs++;
        end else begin
          hold_prev = 1; held = {rsp_id, rsp_err, rsp_data};
        end
      end
      if (|(req_valid & req_ready)) begin
        g = req_ready[1];
        sb.push_back('{id: g, err: stall, data: stall ? '0 : cipher(mode_v[g], msg_v[g], key_v[g])});
        outst = 1; acc[g] = 1;
        if (stall) errs = (errs == 8'hff) ? errs : errs + 8'd1;
      end
    end
  end

  // Master model: random completion latency, stray done pulses while idle, input stability.
  initial begin
    bit act = 0, sent = 0;
    int cnt = 0;
    logic c_mode;
    logic [DW-1:0] c_msg;
    logic [KW-1:0] c_key;
    forever begin
      @(posedge clk); #1;
      if (!rst_n || !m_valid) begin
        act = 0;
        m_done = rst_n && $urandom_range(0, 7) == 0;
        m_result = r128();
      end else if (!act) begin
        act = 1; sent = 0; cnt = $urandom_range(1, 6);
        c_msg = m_msg; c_key = m_key; c_mode = m_mode; m_done = 0;
      end else begin
        chk(m_msg == c_msg && m_key == c_key && m_mode == c_mode, "m_stable", m_msg, c_msg);
        m_done = 0;
        if (!sent && !stall) begin
          cnt--;
          if (cnt == 0) begin m_done = 1; m_result = cipher(c_mode, c_msg, c_key); sent = 1; end
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    rsp_ready = hold ? 1'b0 : (rand_rdy ? $urandom_range(0, 2) != 0 : 1'b1);
  end

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin mode_v[i] = 0; msg_v[i] = 0; key_v[i] = 0; acc[i] = 0; end
    req_valid = 2'b11;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    req_valid = 2'b00; rst_n = 1;
    @(posedge clk); #1;
    issue(0, 1'b0, P1, K1);
    drain();
    chk(job_cnt == jobs, "t1_job_cnt", 256'(job_cnt), 256'(jobs));
    issue(1, 1'b1, C1, K1);
    drain();
    fork
      repeat (2) issue_rand(0);
      repeat (2) issue_rand(1);
    join
    drain();
    rand_rdy = 1;
    fork
      for (int k = 0; k < 12; k++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        issue_rand(0);
      end
      for (int k = 0; k < 12; k++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        issue_rand(1);
      end
    join
    drain();
    chk(job_cnt == jobs, "rand_job_cnt", 256'(job_cnt), 256'(jobs));
    rand_rdy = 0; stall = 1;
    issue_rand(0);
    drain();
    stall = 0;
    chk(err_cnt == errs, "t4_err_cnt", 256'(err_cnt), 256'(errs));
    chk(aborts == 1, "t4_aborts", 256'(aborts), 1);
    hold = 1;
    issue_rand(0);
    n = 0;
    while (!rsp_valid && n < 200) begin @(posedge clk); #1; n++; end
    chk(rsp_valid, "t5_rsp_valid", 256'(rsp_valid), 1);
    fork issue_rand(1); join_none
    repeat (10) begin @(posedge clk); #1; end
    hold = 0;
    wait fork;
    drain();
    stall = 1;
    issue_rand(0);
    repeat (5) @(posedge clk);
    #2 rst_n = 0;
    #1 check_zero("t6_reset");
    repeat (2) @(posedge clk);
    #1 stall = 0; rst_n = 1;
    @(posedge clk); #1;
    issue(0, 1'b0, P1, K1);
    drain();
    chk(job_cnt == jobs, "t6_job_cnt", 256'(job_cnt), 256'(jobs));
    stall = 1;
    repeat (257) issue_rand(int'($urandom_range(0, 1)));
    drain();
    stall = 0;
    chk(err_cnt == errs, "err_cnt_sat", 256'(err_cnt), 256'(errs));
    chk(job_cnt == jobs, "sat_job_cnt", 256'(job_cnt), 256'(jobs));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
